alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 13 +
 rtl/shift_add_mul.sv | 47 ++++
 rtl/alu_sequencer.sv | 110 +++++++++++
 tb/tb_alu_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and FSM state type for the ALU sequencer
// and its multiplier.
package alu_pkg;
   localparam int DATA_WIDTH     = 12;
   localparam int OPERATION_SIZE = 2;
   localparam int FIFO_IN_WIDTH  = 26;
   localparam int FIFO_OUT_WIDTH = 25;

   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   typedef enum logic [2:0] {IDLE, POP, LOAD, EXEC, PUSH} state_t;
endpackage

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per cycle,
// WIDTH cycles after a start pulse. done flags the final step.
module shift_add_mul #(
   parameter int WIDTH = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier_reg;
   logic [CW-1:0]      count_reg;

   assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_reg  <= '0;
         acc_reg    <= '0;
         mplier_reg <= '0;
         count_reg  <= '0;
      end else if (start) begin
         mcand_reg  <= {{WIDTH{1'b0}}, a};
         acc_reg    <= '0;
         mplier_reg <= b;
         count_reg  <= CW'(WIDTH);
      end else if (count_reg != '0) begin
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         count_reg  <= count_reg - 1'b1;
      end
   end

   // The last step's sum is exposed directly so the caller can latch it
   // on the same edge the step would have completed.
   assign done    = (count_reg == CW'(1));
   assign product = acc_next;
endmodule

// File: rtl/alu_sequencer.sv
// Pops {op, data0, data1} from an input FIFO, runs add/mul, and pushes
// {err, value} to an output FIFO, counting completed results.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH     = alu_pkg::DATA_WIDTH,
   parameter int OPERATION_SIZE = alu_pkg::OPERATION_SIZE,
   parameter int FIFO_IN_WIDTH  = alu_pkg::FIFO_IN_WIDTH,
   parameter int FIFO_OUT_WIDTH = alu_pkg::FIFO_OUT_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      empty_in,
   input  logic [FIFO_IN_WIDTH-1:0]  rdata_in,
   output logic                      r_en_in,
   input  logic                      full_out,
   output logic                      w_en_out,
   output logic [FIFO_OUT_WIDTH-1:0] wdata_out,
   output logic                      busy,
   output logic [7:0]                done_count
);
   localparam int VALUE_WIDTH = FIFO_OUT_WIDTH - 1;

   state_t                    state_reg, state_next;
   logic [OPERATION_SIZE-1:0] op_reg;
   logic [DATA_WIDTH-1:0]     data0_reg, data1_reg;
   logic [FIFO_OUT_WIDTH-1:0] result_reg;
   logic [7:0]                done_count_reg;

   logic [OPERATION_SIZE-1:0] in_op;
   logic [DATA_WIDTH-1:0]     in_data0, in_data1;
   logic [DATA_WIDTH:0]       sum;
   logic                      mul_start, mul_done;
   logic [2*DATA_WIDTH-1:0]   product;

   assign in_op    = rdata_in[FIFO_IN_WIDTH-1 -: OPERATION_SIZE];
   assign in_data0 = rdata_in[2*DATA_WIDTH-1 -: DATA_WIDTH];
   assign in_data1 = rdata_in[DATA_WIDTH-1:0];
   assign sum      = {1'b0, data0_reg} + {1'b0, data1_reg};

   // Multiplier operands come straight off the FIFO so stepping starts in
   // the first EXEC cycle.
   shift_add_mul #(.WIDTH(DATA_WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (in_data0),
      .b       (in_data1),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      mul_start  = 1'b0;
      case (state_reg)
         IDLE: if (!empty_in) state_next = POP;
         POP:  state_next = LOAD;
         LOAD: begin
            if (in_op == OP_ADD) begin
               state_next = EXEC;
            end else if (in_op == OP_MUL) begin
               state_next = EXEC;
               mul_start  = 1'b1;
            end else begin
               state_next = PUSH;
            end
         end
         EXEC: if (op_reg == OP_ADD || mul_done) state_next = PUSH;
         PUSH: if (!full_out) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg         <= '0;
         data0_reg      <= '0;
         data1_reg      <= '0;
         result_reg     <= '0;
         done_count_reg <= '0;
      end else begin
         if (state_reg == LOAD) begin
            op_reg    <= in_op;
            data0_reg <= in_data0;
            data1_reg <= in_data1;
            if (in_op != OP_ADD && in_op != OP_MUL)
               result_reg <= {1'b1, {VALUE_WIDTH{1'b0}}};
         end
         if (state_reg == EXEC) begin
            if (op_reg == OP_ADD)
               result_reg <= {1'b0, VALUE_WIDTH'(sum)};
            else if (mul_done)
               result_reg <= {1'b0, VALUE_WIDTH'(product)};
         end
         if (w_en_out) done_count_reg <= done_count_reg + 8'd1;
      end
   end

   assign r_en_in    = (state_reg == POP);
   assign w_en_out   = (state_reg == PUSH) && !full_out;
   assign busy       = (state_reg != IDLE);
   assign wdata_out  = result_reg;
   assign done_count = done_count_reg;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a FIFO model feeds operations, a
// scoreboard queue holds expected results and latencies.
module tb_alu_sequencer;
   typedef struct {
      logic [24:0] data;
      int          lat;
      int          start;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        empty_in = 1'b1;
   logic [25:0] rdata_in = '0;
   logic        r_en_in;
   logic        full_out = 1'b0;
   logic        w_en_out;
   logic [24:0] wdata_out;
   logic        busy;
   logic [7:0]  done_count;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_push = 0;
   bit          have_last_push = 0;
   bit          bb_mode = 0;
   bit          pop_pending = 0;
   logic [7:0]  exp_count = '0;
   logic [25:0] in_q[$];
   exp_t        exp_q[$];

   alu_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .empty_in   (empty_in),
      .rdata_in   (rdata_in),
      .r_en_in    (r_en_in),
      .full_out   (full_out),
      .w_en_out   (w_en_out),
      .wdata_out  (wdata_out),
      .busy       (busy),
      .done_count (done_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic enqueue(input logic [1:0] op, input logic [11:0] d0, input logic [11:0] d1,
                          input logic [24:0] res, input int lat);
      exp_t e;
      in_q.push_back({op, d0, d1});
      e.data  = res;
      e.lat   = lat;
      e.start = cyc;
      exp_q.push_back(e);
      empty_in = 1'b0;
   endtask

   task automatic monitor();
      exp_t e;
      if (r_en_in) begin
         pop_pending = 1'b1;
         if (bb_mode && have_last_push) check("pop_after_push", cyc - last_push, 2);
      end
      if (w_en_out) begin
         check("push_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wdata", 32'(wdata_out), 32'(e.data));
            if (e.lat > 0) check("latency", cyc - e.start, e.lat);
         end
         check("done_count_run", 32'(done_count), 32'(exp_count));
         exp_count = exp_count + 8'd1;
         last_push = cyc;
         have_last_push = 1'b1;
      end
   endtask

   // Outputs are sampled at the falling edge; FIFO inputs change just after
   // the rising edge.
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
      if (pop_pending) begin
         rdata_in = in_q.pop_front();
         pop_pending = 1'b0;
      end
      empty_in = (in_q.size() == 0);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
      check("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      int start_cyc;
      logic [11:0] a, b;

      // Reset state
      repeat (2) tick();
      check("rst_r_en", r_en_in, 0);
      check("rst_w_en", w_en_out, 0);
      check("rst_wdata", wdata_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done_count, 0);
      rst_n = 1'b1;
      tick();
      check("idle_busy", busy, 0);

      // Add, mul, invalid with latency checks
      enqueue(2'b01, 12'h0FF, 12'h001, 25'h0000100, 4);
      drain(30);
      check("add_done_count", done_count, 1);
      enqueue(2'b10, 12'hFFF, 12'hFFF, 25'h0FFE001, 15);
      drain(40);
      enqueue(2'b11, 12'h123, 12'h456, 25'h1000000, 3);
      drain(30);
      enqueue(2'b00, 12'h7FF, 12'h001, 25'h1000000, 3);
      drain(30);
      enqueue(2'b10, 12'h0AB, 12'h012, 25'h0000C06, 15);
      drain(40);

      // Backpressure: held five cycles in PUSH
      full_out = 1'b1;
      enqueue(2'b01, 12'd3, 12'd4, 25'h0000007, 9);
      repeat (4) tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_w_en", w_en_out, 0);
         check("bp_wdata", wdata_out, 25'h0000007);
         tick();
      end
      full_out = 1'b0;
      drain(10);
      check("bp_done_count", done_count, 6);

      // Reset during the sixth EXEC cycle of a multiply
      enqueue(2'b10, 12'h456, 12'h789, 25'h0000000, 0);
      repeat (8) tick();
      check("mid_mul_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_wdata", wdata_out, 0);
      check("arst_w_en", w_en_out, 0);
      check("arst_r_en", r_en_in, 0);
      check("arst_done", done_count, 0);
      void'(exp_q.pop_back());
      exp_count = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      check("no_push_after_rst", done_count, 0);
      enqueue(2'b10, 12'd3, 12'd5, 25'h000000F, 15);
      drain(40);
      check("post_rst_done", done_count, 1);

      // Wrap: 256 back-to-back adds
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_count = '0;
      tick();
      start_cyc = cyc;
      for (int i = 0; i < 256; i++) begin
         a = 12'($urandom_range(0, 4095));
         b = 12'($urandom_range(0, 4095));
         enqueue(2'b01, a, b, 25'({1'b0, a} + {1'b0, b}), (i == 0) ? 4 : 0);
      end
      bb_mode = 1'b1;
      have_last_push = 1'b0;
      drain(256 * 5 + 20);
      bb_mode = 1'b0;
      check("wrap_done_count", done_count, 0);
      check("wrap_span", last_push - start_cyc, 256 * 5 - 1);
      tick();
      check("final_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
